cam_alloc: RTL and testbench

- Second-generation tag CAM cache with automatic slot allocation. It replaces caller-supplied write addresses with internal free-slot search and round-robin eviction.
- Lookups are registered with a fixed 1-cycle latency.
- Adds invalidate-by-tag, a multi-cycle flush walker, an occupancy count and a full flag.
- Sits between the requester and the backing store as a small fully-associative tag/data cache.

---
 rtl/cam_alloc_pkg.sv | 18 +
 rtl/cam_prio_enc.sv | 22 ++
 rtl/cam_alloc.sv | 180 ++++++++++++++++++
 tb/tb_cam_alloc.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cam_alloc_pkg.sv
// Shared types and helpers for the cam_alloc tag cache.
// Optional statistics counters are enabled with the CAM_STATS_EN macro.
package cam_alloc_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } state_t;

    // Saturation ceiling of the optional hit/miss statistics counters
    localparam logic [15:0] SAT_MAX = 16'hFFFF;

    // Advance an entry index by one, wrapping from words-1 back to 0
    function automatic int next_idx(input int idx, input int words);
        return (idx == words - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/cam_prio_enc.sv
// Lowest-set-bit priority encoder: returns the index of the lowest set bit
// of vec (0 when none) and a flag telling whether any bit is set.
module cam_prio_enc #(
    parameter int N = 8,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] vec,
    output logic [W-1:0] idx,
    output logic         any
);

    // Scan from the top down so the lowest set bit is the last one written
    always_comb begin
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (vec[i]) idx = W'(i);
        end
    end

    assign any = |vec;

endmodule

// File: rtl/cam_alloc.sv
// cam_alloc: fully-associative tag/data cache with automatic slot allocation,
// round-robin eviction, invalidate-by-tag, a multi-cycle flush walker and
// occupancy tracking. Define CAM_STATS_EN to add hit_cnt/miss_cnt outputs.
module cam_alloc
    import cam_alloc_pkg::*;
#(
    parameter int WORDS  = 8,
    parameter int BITS   = 8,
    parameter int TAG_SZ = 8,
    parameter int IDX_W  = $clog2(WORDS),
    parameter int CNT_W  = $clog2(WORDS + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              read,
    input  logic [TAG_SZ-1:0] check_tag,
    input  logic              write_,
    input  logic [TAG_SZ-1:0] new_tag,
    input  logic [BITS-1:0]   wdata,
    input  logic              inv,
    input  logic [TAG_SZ-1:0] inv_tag,
    input  logic              flush,
    output logic              rd_valid,
    output logic              found_it,
    output logic [BITS-1:0]   data,
    output logic [IDX_W-1:0]  hit_index,
    output logic              busy,
    output logic              full,
    output logic [CNT_W-1:0]  count
`ifdef CAM_STATS_EN
    ,
    output logic [15:0]       hit_cnt,
    output logic [15:0]       miss_cnt
`endif
);

    logic [WORDS-1:0]  valid;
    logic [TAG_SZ-1:0] tags [WORDS];
    logic [BITS-1:0]   mem  [WORDS];
    logic [IDX_W-1:0]  victim;
    logic [IDX_W-1:0]  walk_idx;
    state_t            state;

    logic [WORDS-1:0]  rd_match;
    logic [WORDS-1:0]  inv_match;
    logic [WORDS-1:0]  wr_match;
    logic [WORDS-1:0]  valid_ai;
    logic [WORDS-1:0]  valid_next;
    logic [CNT_W-1:0]  count_next;
    logic              do_inv;
    logic              do_write;
    logic              idle;
    logic [IDX_W-1:0]  rd_idx, wr_idx, free_idx, wr_target;
    logic              rd_any, wr_hit, free_any;

    assign idle     = (state == IDLE);
    assign do_inv   = idle && !flush && inv;
    assign do_write = idle && !flush && !write_;
    assign full     = (count == CNT_W'(WORDS));

    // Tag comparisons; invalidation is folded in before the write search
    // so a write in the same cycle sees the freed slots
    always_comb begin
        rd_match  = '0;
        inv_match = '0;
        wr_match  = '0;
        for (int i = 0; i < WORDS; i++) begin
            rd_match[i]  = valid[i] && (tags[i] == check_tag);
            inv_match[i] = valid[i] && (tags[i] == inv_tag);
        end
        valid_ai = do_inv ? (valid & ~inv_match) : valid;
        for (int i = 0; i < WORDS; i++) begin
            wr_match[i] = valid_ai[i] && (tags[i] == new_tag);
        end
    end

    cam_prio_enc #(.N(WORDS), .W(IDX_W)) u_rd_enc (
        .vec (rd_match),
        .idx (rd_idx),
        .any (rd_any)
    );

    cam_prio_enc #(.N(WORDS), .W(IDX_W)) u_wr_enc (
        .vec (wr_match),
        .idx (wr_idx),
        .any (wr_hit)
    );

    cam_prio_enc #(.N(WORDS), .W(IDX_W)) u_free_enc (
        .vec (~valid_ai),
        .idx (free_idx),
        .any (free_any)
    );

    // Pick the write slot (hit, then first free, then victim) and build the
    // next valid vector including the flush walker's clear
    always_comb begin
        wr_target  = wr_hit ? wr_idx : (free_any ? free_idx : victim);
        valid_next = valid_ai;
        if (do_write) valid_next[wr_target] = 1'b1;
        if (state == FLUSH) valid_next[walk_idx] = 1'b0;
        count_next = '0;
        for (int i = 0; i < WORDS; i++) begin
            count_next = count_next + CNT_W'(valid_next[i]);
        end
    end

    // Storage, occupancy, victim pointer and registered lookup results
    always_ff @(posedge clk) begin
        if (rst) begin
            valid     <= '0;
            count     <= '0;
            victim    <= '0;
            rd_valid  <= 1'b0;
            found_it  <= 1'b0;
            data      <= '0;
            hit_index <= '0;
            for (int i = 0; i < WORDS; i++) begin
                tags[i] <= '0;
                mem[i]  <= '0;
            end
        end else begin
            valid <= valid_next;
            count <= count_next;
            if (do_write) begin
                tags[wr_target] <= new_tag;
                mem[wr_target]  <= wdata;
                if (!wr_hit && !free_any) victim <= IDX_W'(next_idx(int'(victim), WORDS));
            end
            rd_valid  <= read && idle;
            found_it  <= read && idle && rd_any;
            data      <= (read && idle && rd_any) ? mem[rd_idx] : '0;
            hit_index <= (read && idle && rd_any) ? rd_idx : '0;
        end
    end

    // Flush walker: clears one entry per cycle for WORDS cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            walk_idx <= '0;
            busy     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (flush) begin
                        state    <= FLUSH;
                        walk_idx <= '0;
                        busy     <= 1'b1;
                    end
                end
                FLUSH: begin
                    walk_idx <= IDX_W'(next_idx(int'(walk_idx), WORDS));
                    if (walk_idx == IDX_W'(WORDS - 1)) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef CAM_STATS_EN
    // Saturating hit/miss counters driven by each lookup result pulse
    always_ff @(posedge clk) begin
        if (rst || (idle && flush)) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else if (rd_valid) begin
            if (found_it) begin
                if (hit_cnt != SAT_MAX) hit_cnt <= hit_cnt + 16'd1;
            end else begin
                if (miss_cnt != SAT_MAX) miss_cnt <= miss_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_cam_alloc.sv
// Self-checking bench for cam_alloc with WORDS=4: a table of one-cycle
// vectors for lookup/allocate/evict/invalidate, then hand-written flush,
// reset-during-flush and (when CAM_STATS_EN is defined) statistics sequences.
module tb_cam_alloc;

    logic       clk = 1'b0;
    logic       rst;
    logic       read;
    logic [7:0] check_tag;
    logic       write_;
    logic [7:0] new_tag;
    logic [7:0] wdata;
    logic       inv;
    logic [7:0] inv_tag;
    logic       flush;
    logic       rd_valid;
    logic       found_it;
    logic [7:0] data;
    logic [1:0] hit_index;
    logic       busy;
    logic       full;
    logic [2:0] count;
`ifdef CAM_STATS_EN
    logic [15:0] hit_cnt;
    logic [15:0] miss_cnt;
`endif

    int assertCount = 0;
    int failCount   = 0;

    typedef struct {
        logic       rd;
        logic [7:0] ctag;
        logic       wr;
        logic [7:0] ntag;
        logic [7:0] wd;
        logic       iv;
        logic [7:0] itag;
        logic       eRdv;
        logic       eFound;
        logic [7:0] eData;
        logic [1:0] eIdx;
        logic       eFull;
        logic [2:0] eCnt;
    } vec_t;

    vec_t vecs[$];

    cam_alloc #(.WORDS(4), .BITS(8), .TAG_SZ(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .read      (read),
        .check_tag (check_tag),
        .write_    (write_),
        .new_tag   (new_tag),
        .wdata     (wdata),
        .inv       (inv),
        .inv_tag   (inv_tag),
        .flush     (flush),
        .rd_valid  (rd_valid),
        .found_it  (found_it),
        .data      (data),
        .hit_index (hit_index),
        .busy      (busy),
        .full      (full),
        .count     (count)
`ifdef CAM_STATS_EN
        ,
        .hit_cnt   (hit_cnt),
        .miss_cnt  (miss_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic rd, input logic [7:0] ctag,
                                input logic wr, input logic [7:0] ntag, input logic [7:0] wd,
                                input logic iv, input logic [7:0] itag,
                                input logic eRdv, input logic eFound, input logic [7:0] eData,
                                input logic [1:0] eIdx, input logic eFull, input logic [2:0] eCnt);
        vec_t v;
        v.rd = rd; v.ctag = ctag; v.wr = wr; v.ntag = ntag; v.wd = wd;
        v.iv = iv; v.itag = itag; v.eRdv = eRdv; v.eFound = eFound;
        v.eData = eData; v.eIdx = eIdx; v.eFull = eFull; v.eCnt = eCnt;
        return v;
    endfunction

    // Single field comparison feeding the shared counters
    task automatic checkField(input string nm, input logic [31:0] act, input logic [31:0] exp);
        assertCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Compare every observable output against expected values
    task automatic checkOutput(input string nm, input logic eRdv, input logic eFound,
                               input logic [7:0] eData, input logic [1:0] eIdx,
                               input logic eBusy, input logic eFull, input logic [2:0] eCnt);
        checkField({nm, "_rd_valid"},  32'(rd_valid),  32'(eRdv));
        checkField({nm, "_found_it"},  32'(found_it),  32'(eFound));
        checkField({nm, "_data"},      32'(data),      32'(eData));
        checkField({nm, "_hit_index"}, 32'(hit_index), 32'(eIdx));
        checkField({nm, "_busy"},      32'(busy),      32'(eBusy));
        checkField({nm, "_full"},      32'(full),      32'(eFull));
        checkField({nm, "_count"},     32'(count),     32'(eCnt));
    endtask

    task automatic idleInputs();
        read = 1'b0; check_tag = '0; write_ = 1'b1; new_tag = '0; wdata = '0;
        inv = 1'b0; inv_tag = '0; flush = 1'b0;
    endtask

    // Drive one vector at a falling edge and wait past the next rising edge
    task automatic applyStimulus(input vec_t v);
        read = v.rd; check_tag = v.ctag; write_ = ~v.wr; new_tag = v.ntag; wdata = v.wd;
        inv = v.iv; inv_tag = v.itag; flush = 1'b0;
        @(negedge clk);
    endtask

    task automatic doReset();
        idleInputs();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic cycle();
        @(negedge clk);
    endtask

    initial begin
        doReset();
        checkOutput("reset", 0, 0, 8'h00, 0, 0, 0, 0);

        // Fill, hit, evict round-robin, update in place, invalidate, inv+write
        vecs.push_back(mk(0,8'h00, 1,8'h10,8'hA1, 0,8'h00, 0,0,8'h00,0, 0,1));
        vecs.push_back(mk(0,8'h00, 1,8'h20,8'hA2, 0,8'h00, 0,0,8'h00,0, 0,2));
        vecs.push_back(mk(0,8'h00, 1,8'h30,8'hA3, 0,8'h00, 0,0,8'h00,0, 0,3));
        vecs.push_back(mk(0,8'h00, 1,8'h40,8'hA4, 0,8'h00, 0,0,8'h00,0, 1,4));
        vecs.push_back(mk(1,8'h30, 0,8'h00,8'h00, 0,8'h00, 1,1,8'hA3,2, 1,4));
        vecs.push_back(mk(0,8'h00, 1,8'h50,8'hB5, 0,8'h00, 0,0,8'h00,0, 1,4));
        vecs.push_back(mk(0,8'h00, 1,8'h60,8'hB6, 0,8'h00, 0,0,8'h00,0, 1,4));
        vecs.push_back(mk(1,8'h10, 0,8'h00,8'h00, 0,8'h00, 1,0,8'h00,0, 1,4));
        vecs.push_back(mk(1,8'h50, 0,8'h00,8'h00, 0,8'h00, 1,1,8'hB5,0, 1,4));
        vecs.push_back(mk(0,8'h00, 1,8'h70,8'hC7, 0,8'h00, 0,0,8'h00,0, 1,4));
        vecs.push_back(mk(0,8'h00, 1,8'h80,8'hC8, 0,8'h00, 0,0,8'h00,0, 1,4));
        vecs.push_back(mk(0,8'h00, 1,8'h90,8'hC9, 0,8'h00, 0,0,8'h00,0, 1,4));
        vecs.push_back(mk(0,8'h00, 1,8'hA0,8'hCA, 0,8'h00, 0,0,8'h00,0, 1,4));
        vecs.push_back(mk(1,8'h90, 0,8'h00,8'h00, 0,8'h00, 1,1,8'hC9,0, 1,4));
        vecs.push_back(mk(1,8'hA0, 0,8'h00,8'h00, 0,8'h00, 1,1,8'hCA,1, 1,4));
        vecs.push_back(mk(0,8'h00, 1,8'hB0,8'hBB, 0,8'h00, 0,0,8'h00,0, 1,4));
        vecs.push_back(mk(1,8'hB0, 0,8'h00,8'h00, 0,8'h00, 1,1,8'hBB,2, 1,4));
        vecs.push_back(mk(0,8'h00, 1,8'hA0,8'hCC, 0,8'h00, 0,0,8'h00,0, 1,4));
        vecs.push_back(mk(1,8'hA0, 0,8'h00,8'h00, 0,8'h00, 1,1,8'hCC,1, 1,4));
        vecs.push_back(mk(0,8'h00, 0,8'h00,8'h00, 1,8'h80, 0,0,8'h00,0, 0,3));
        vecs.push_back(mk(0,8'h00, 1,8'hD0,8'hD5, 0,8'h00, 0,0,8'h00,0, 1,4));
        vecs.push_back(mk(1,8'hD0, 0,8'h00,8'h00, 0,8'h00, 1,1,8'hD5,3, 1,4));
        vecs.push_back(mk(0,8'h00, 1,8'h90,8'hDD, 1,8'h90, 0,0,8'h00,0, 1,4));
        vecs.push_back(mk(1,8'h90, 0,8'h00,8'h00, 0,8'h00, 1,1,8'hDD,0, 1,4));
        vecs.push_back(mk(0,8'h00, 1,8'hE0,8'hE1, 0,8'h00, 0,0,8'h00,0, 1,4));
        vecs.push_back(mk(1,8'hE0, 0,8'h00,8'h00, 0,8'h00, 1,1,8'hE1,3, 1,4));
        vecs.push_back(mk(1,8'hD0, 0,8'h00,8'h00, 0,8'h00, 1,0,8'h00,0, 1,4));
        vecs.push_back(mk(0,8'h00, 1,8'hF0,8'hF1, 1,8'hA0, 0,0,8'h00,0, 1,4));
        vecs.push_back(mk(1,8'hF0, 0,8'h00,8'h00, 0,8'h00, 1,1,8'hF1,1, 1,4));
        vecs.push_back(mk(1,8'hA0, 0,8'h00,8'h00, 0,8'h00, 1,0,8'h00,0, 1,4));
        vecs.push_back(mk(0,8'h00, 0,8'h00,8'h00, 1,8'h77, 0,0,8'h00,0, 1,4));
        vecs.push_back(mk(1,8'h11, 1,8'h11,8'h12, 0,8'h00, 1,0,8'h00,0, 1,4));
        vecs.push_back(mk(1,8'h11, 0,8'h00,8'h00, 0,8'h00, 1,1,8'h12,0, 1,4));

        foreach (vecs[i]) begin
            applyStimulus(vecs[i]);
            checkOutput($sformatf("vec%0d", i), vecs[i].eRdv, vecs[i].eFound, vecs[i].eData,
                        vecs[i].eIdx, 1'b0, vecs[i].eFull, vecs[i].eCnt);
        end
        idleInputs();

        // Flush with a read in the start cycle; traffic during busy is ignored
        flush = 1'b1; read = 1'b1; check_tag = 8'hB0;
        cycle();
        checkOutput("flush_start", 1, 1, 8'hBB, 2, 1, 1, 4);
        read = 1'b1; check_tag = 8'hF0; write_ = 1'b0; new_tag = 8'h33; wdata = 8'h44;
        inv = 1'b1; inv_tag = 8'hF0;
        cycle();
        checkOutput("flush_c1", 0, 0, 8'h00, 0, 1, 0, 3);
        flush = 1'b0;
        cycle();
        checkOutput("flush_c2", 0, 0, 8'h00, 0, 1, 0, 2);
        cycle();
        checkOutput("flush_c3", 0, 0, 8'h00, 0, 1, 0, 1);
        cycle();
        checkOutput("flush_c4", 0, 0, 8'h00, 0, 0, 0, 0);
        idleInputs();
        read = 1'b1; check_tag = 8'hF0;
        cycle();
        checkOutput("post_flush_F0", 1, 0, 8'h00, 0, 0, 0, 0);
        check_tag = 8'h33;
        cycle();
        checkOutput("post_flush_33", 1, 0, 8'h00, 0, 0, 0, 0);
        check_tag = 8'hB0;
        cycle();
        checkOutput("post_flush_B0", 1, 0, 8'h00, 0, 0, 0, 0);
        idleInputs();

        // Reset in the middle of a flush aborts it
        write_ = 1'b0; new_tag = 8'h42; wdata = 8'h24;
        cycle();
        checkOutput("pre_abort_write", 0, 0, 8'h00, 0, 0, 0, 1);
        idleInputs();
        read = 1'b1; check_tag = 8'h42;
        cycle();
        checkOutput("pre_abort_read", 1, 1, 8'h24, 0, 0, 0, 1);
        idleInputs();
        flush = 1'b1;
        cycle();
        checkOutput("abort_busy", 0, 0, 8'h00, 0, 1, 0, 1);
        flush = 1'b0; rst = 1'b1;
        cycle();
        checkOutput("abort_rst", 0, 0, 8'h00, 0, 0, 0, 0);
        rst = 1'b0;
        cycle();
        checkOutput("abort_after", 0, 0, 8'h00, 0, 0, 0, 0);
        read = 1'b1; check_tag = 8'h42;
        cycle();
        checkOutput("abort_read", 1, 0, 8'h00, 0, 0, 0, 0);
        idleInputs();

`ifdef CAM_STATS_EN
        // Three hits and two misses, then a flush clears the counters
        doReset();
        write_ = 1'b0; new_tag = 8'h01; wdata = 8'h11;
        cycle();
        new_tag = 8'h02; wdata = 8'h22;
        cycle();
        idleInputs();
        read = 1'b1;
        check_tag = 8'h01; cycle();
        check_tag = 8'h02; cycle();
        check_tag = 8'h01; cycle();
        check_tag = 8'h03; cycle();
        check_tag = 8'h04; cycle();
        idleInputs();
        cycle();
        cycle();
        checkField("stats_hit",  32'(hit_cnt),  32'd3);
        checkField("stats_miss", 32'(miss_cnt), 32'd2);
        flush = 1'b1;
        cycle();
        idleInputs();
        for (int k = 0; k < 5; k++) cycle();
        checkField("stats_hit_flush",  32'(hit_cnt),  32'd0);
        checkField("stats_miss_flush", 32'(miss_cnt), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
